// File: rtl/alu_dec_stage.sv
// alu_dec_stage: registered RV32I decode stage producing the ALU control word.
// Optional feature macro: ALU_DEC_SKID_EN
//   defined   -> two-entry skid buffer, in_ready comes straight from a flop
//   undefined -> single output register, in_ready = ~out_valid | out_ready
//
// Handshake: a word moves across a port on a rising edge where valid and ready
// are both high; valid never depends on ready, and a presented output word is
// held unchanged until it is taken.
module alu_dec_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alufn,
  output logic [4:0]      shamt,
  output logic            shamt_reg,
  output logic [XLEN-1:0] imm,
  output logic            b_sel,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [3:0]      alufn;
    logic [4:0]      shamt;
    logic            shamt_reg;
    logic [XLEN-1:0] imm;
    logic            b_sel;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;
  } dec_t;

  // funct3 -> ALU op for OP / OP-IMM; alt picks SUB/SRA
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       wr;
  dec_t       dec;
  dec_t       main_q;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  // Combinational decode of the incoming instruction
  always_comb begin
    dec           = '0;
    wr            = 1'b0;
    dec.shamt     = in_instr[24:20];
    dec.rs1       = in_instr[19:15];
    dec.rs2       = in_instr[24:20];
    dec.rd        = in_instr[11:7];
    dec.imm       = {{20{in_instr[31]}}, in_instr[31:20]};
    dec.alufn     = ALU_ADD;
    case (opc)
      OPC_OP: begin
        dec.alufn     = arith_op(f3, f7[5]);
        dec.shamt_reg = (f3 == 3'b001) || (f3 == 3'b101);
        dec.illegal   = ((f7 != 7'b0000000) && (f7 != 7'b0100000)) ||
                        (f7[5] && (f3 != 3'b000) && (f3 != 3'b101));
        wr            = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.alufn   = arith_op(f3, (f3 == 3'b101) && f7[5]);
        dec.b_sel   = 1'b1;
        dec.illegal = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                      ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
        wr          = 1'b1;
      end
      OPC_LUI: begin
        dec.alufn = ALU_PASS;
        dec.imm   = {in_instr[31:12], 12'b0};
        dec.b_sel = 1'b1;
        wr        = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm   = {in_instr[31:12], 12'b0};
        dec.b_sel = 1'b1;
        wr        = 1'b1;
      end
      OPC_JAL: begin
        dec.imm   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
        dec.b_sel = 1'b1;
        wr        = 1'b1;
      end
      OPC_JALR, OPC_LOAD: begin
        dec.b_sel = 1'b1;
        wr        = 1'b1;
      end
      OPC_STORE: begin
        dec.imm   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec.b_sel = 1'b1;
      end
      OPC_BRANCH: begin
        dec.alufn = ALU_SUB;
        dec.imm   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) dec.alufn = ALU_ADD;
    dec.reg_write = wr && (dec.rd != 5'd0) && !dec.illegal;
  end

`ifdef ALU_DEC_SKID_EN
  dec_t skid_q;
  logic skid_empty;

  assign in_ready = skid_empty;

  // Main + skid registers; the skid word drains into main ahead of new input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      skid_empty <= 1'b1;
    end else if (!skid_empty) begin
      if (out_ready) begin
        main_q     <= skid_q;
        skid_empty <= 1'b1;
      end
    end else if (in_valid) begin
      if (!out_valid || out_ready) begin
        main_q    <= dec;
        out_valid <= 1'b1;
      end else begin
        skid_q     <= dec;
        skid_empty <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  // Single output register, reloaded whenever the slot is free or being emptied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      main_q    <= '0;
    end else if (in_valid && in_ready) begin
      main_q    <= dec;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign alufn     = main_q.alufn;
  assign shamt     = main_q.shamt;
  assign shamt_reg = main_q.shamt_reg;
  assign imm       = main_q.imm;
  assign b_sel     = main_q.b_sel;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign rd        = main_q.rd;
  assign reg_write = main_q.reg_write;
  assign illegal   = main_q.illegal;

endmodule
